// File: rtl/lock_sequencer.sv
// Multi-digit combination-lock controller: digit-by-digit entry against a stored code,
// failure counting with timed lockout and terminal alarm, and an atomic staged code change.
module lock_sequencer #(
    parameter int             DIGITS         = 4,
    parameter int             DW             = 4,
    parameter int             MAX_FAILS      = 3,
    parameter int             LOCKOUT_CYCLES = 50000000,
    parameter logic [DW-1:0]  DEFAULT_DIGIT  = 4'b0110,
    localparam int            IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int            FW = $clog2(MAX_FAILS + 1),
    localparam int            TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] X,
    input  logic          enter_pulse,
    input  logic          change_pulse,
    output logic          open,
    output logic          new_code,
    output logic          alarm,
    output logic          locked,
    output logic [IW-1:0] digit_index,
    output logic [FW-1:0] fail_count
);

    typedef enum logic [2:0] {IDLE, OPEN, CHANGE, LOCKOUT, ALARM} state_t;

    state_t        state;
    logic [DW-1:0] code  [DIGITS];
    logic [DW-1:0] stage [DIGITS];
    logic [IW-1:0] idx;
    logic          mismatch;
    logic [TW-1:0] timer;
    logic [FW-1:0] fails;

    logic last_digit;
    logic miss_now;

    assign last_digit = (idx == IW'(DIGITS - 1));
    assign miss_now   = mismatch | (X != code[idx]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            mismatch <= 1'b0;
            timer    <= '0;
            fails    <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                code[i]  <= DEFAULT_DIGIT;
                stage[i] <= DEFAULT_DIGIT;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A change strobe only discards the partial entry; it never counts as a failure.
                    if (change_pulse) begin
                        idx      <= '0;
                        mismatch <= 1'b0;
                    end else if (enter_pulse) begin
                        if (last_digit) begin
                            idx      <= '0;
                            mismatch <= 1'b0;
                            if (!miss_now) begin
                                state <= OPEN;
                                fails <= '0;
                            end else if (int'(fails) + 1 == MAX_FAILS) begin
                                state <= ALARM;
                                fails <= FW'(MAX_FAILS);
                            end else begin
                                state <= LOCKOUT;
                                fails <= fails + FW'(1);
                                timer <= TW'(LOCKOUT_CYCLES - 1);
                            end
                        end else begin
                            idx      <= idx + IW'(1);
                            mismatch <= miss_now;
                        end
                    end
                end
                OPEN: begin
                    if (change_pulse) begin
                        state <= CHANGE;
                        idx   <= '0;
                    end else if (enter_pulse) begin
                        state <= IDLE;
                    end
                end
                CHANGE: begin
                    if (change_pulse) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else if (enter_pulse) begin
                        stage[idx] <= X;
                        if (last_digit) begin
                            // Commit in one edge, folding in the digit arriving right now.
                            for (int i = 0; i < DIGITS; i++) begin
                                code[i] <= (IW'(i) == idx) ? X : stage[i];
                            end
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ALARM: begin
                    state <= ALARM;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign open        = (state == OPEN);
    assign new_code    = (state == CHANGE);
    assign alarm       = (state == ALARM);
    assign locked      = (state == LOCKOUT);
    assign digit_index = idx;
    assign fail_count  = fails;

endmodule
